// File: rtl/uart_imem_if.sv
// uart_imem_if: byte-level UART handshake plus the instruction-memory write
// port used by the boot loader.
//   master : loader side (consumes rx bytes, drives echo and imem writes)
//   slave  : UART / memory side
// Parameter AW: imem address width.
interface uart_imem_if #(
  parameter int AW = 4
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ack;
  logic [7:0]    tx_data;
  logic          tx_wr;
  logic          tx_busy;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    output rx_ack, tx_data, tx_wr, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    input  rx_ack, tx_data, tx_wr, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: boot sequencer between the UART and the CPU imem.
// Parses ASCII hex from the host into 32-bit words (MSB nibble first),
// writes them to consecutive imem addresses and echoes every byte.
// 'G'/'g' starts the CPU, 'R'/'r' stops it and rewinds loading.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : uart_imem_if.master (rx_data/rx_valid/rx_ack,
//                 tx_data/tx_wr/tx_busy, imem_we/imem_addr/imem_wdata)
//   cpu_start   : level, high while the CPU runs
//   word_count  : words written since reset or 'R' (0..DEPTH)
//   overflow    : sticky, a complete word arrived with imem full
//
// Build option: define BOOT_CSUM_EN to report the 8-bit byte checksum of
// the loaded image as two uppercase hex characters before the CPU starts.
module uart_imem_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_imem_if.master bus,
  output logic        cpu_start,
  output logic [AW:0] word_count,
  output logic        overflow
);

`ifdef BOOT_CSUM_EN
  typedef enum logic [2:0] {
    IDLE, GUARD, CSUM_WAIT_HI, CSUM_HI, CSUM_WAIT_LO, CSUM_LO
  } state_t;
`else
  typedef enum logic [0:0] {IDLE, GUARD} state_t;
`endif

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic          rx_ack_q, rx_ack_d;
  logic          tx_wr_q, tx_wr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          imem_we_q, imem_we_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]   imem_wdata_q, imem_wdata_d;
  logic          cpu_start_q, cpu_start_d;
  logic [AW:0]   wc_q, wc_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [2:0]    nib_q, nib_d;
  logic [31:0]   shift_q, shift_d;
  logic          go_q, go_d;
  logic [31:0]   word;
`ifdef BOOT_CSUM_EN
  logic [7:0]    csum_q, csum_d;
  logic          gap_q, gap_d;
`endif

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  // Letters in both cases carry 1..6 in their low nibble.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : (c[3:0] + 4'd9);
  endfunction

`ifdef BOOT_CSUM_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`endif

  // Outputs are registered, so the echo/ack/write pulses land in the
  // cycle spent in GUARD: GUARD and the echo cycle are the same cycle.
  always_comb begin
    state_d      = state_q;
    rx_ack_d     = 1'b0;
    tx_wr_d      = 1'b0;
    tx_data_d    = tx_data_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_start_d  = cpu_start_q;
    wc_d         = wc_q;
    ovf_d        = ovf_q;
    wptr_d       = wptr_q;
    nib_d        = nib_q;
    shift_d      = shift_q;
    go_d         = go_q;
    word         = '0;
`ifdef BOOT_CSUM_EN
    csum_d       = csum_q;
    gap_d        = gap_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.rx_valid && !bus.tx_busy) begin
          rx_ack_d  = 1'b1;
          tx_wr_d   = 1'b1;
          tx_data_d = bus.rx_data;
          state_d   = GUARD;
          if (bus.rx_data == 8'h52 || bus.rx_data == 8'h72) begin
            cpu_start_d = 1'b0;
            wptr_d      = '0;
            wc_d        = '0;
            nib_d       = '0;
            ovf_d       = 1'b0;
            go_d        = 1'b0;
`ifdef BOOT_CSUM_EN
            csum_d      = '0;
`endif
          end else if (bus.rx_data == 8'h47 || bus.rx_data == 8'h67) begin
            if (!cpu_start_q) begin
              nib_d = '0;
              go_d  = 1'b1;
            end
          end else if (is_hex(bus.rx_data) && !cpu_start_q) begin
            word    = {shift_q[27:0], hex_val(bus.rx_data)};
            shift_d = word;
            if (nib_q == 3'd7) begin
              nib_d = '0;
              if (wc_q < DEPTH_W) begin
                imem_we_d    = 1'b1;
                imem_addr_d  = wptr_q;
                imem_wdata_d = word;
                wptr_d       = wptr_q + 1'b1;
                wc_d         = wc_q + 1'b1;
`ifdef BOOT_CSUM_EN
                csum_d = csum_q + word[31:24] + word[23:16] +
                         word[15:8] + word[7:0];
`endif
              end else begin
                ovf_d = 1'b1;
              end
            end else begin
              nib_d = nib_q + 3'd1;
            end
          end
        end
      end

      GUARD: begin
        state_d = IDLE;
        if (go_q) begin
          go_d = 1'b0;
`ifdef BOOT_CSUM_EN
          gap_d   = 1'b0;
          state_d = CSUM_WAIT_HI;
`else
          cpu_start_d = 1'b1;
`endif
        end
      end

`ifdef BOOT_CSUM_EN
      CSUM_WAIT_HI: begin
        if (!bus.tx_busy) begin
          tx_wr_d   = 1'b1;
          tx_data_d = hex_ascii(csum_q[7:4]);
          state_d   = CSUM_HI;
        end
      end

      // First cycle carries the strobe, second is the guard cycle.
      CSUM_HI: begin
        if (!gap_q) begin
          gap_d = 1'b1;
        end else begin
          gap_d   = 1'b0;
          state_d = CSUM_WAIT_LO;
        end
      end

      CSUM_WAIT_LO: begin
        if (!bus.tx_busy) begin
          tx_wr_d   = 1'b1;
          tx_data_d = hex_ascii(csum_q[3:0]);
          state_d   = CSUM_LO;
        end
      end

      CSUM_LO: begin
        if (!gap_q) begin
          gap_d = 1'b1;
        end else begin
          gap_d       = 1'b0;
          cpu_start_d = 1'b1;
          state_d     = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_ack_q     <= 1'b0;
      tx_wr_q      <= 1'b0;
      tx_data_q    <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_start_q  <= 1'b0;
      wc_q         <= '0;
      ovf_q        <= 1'b0;
      wptr_q       <= '0;
      nib_q        <= '0;
      shift_q      <= '0;
      go_q         <= 1'b0;
`ifdef BOOT_CSUM_EN
      csum_q       <= '0;
      gap_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_ack_q     <= rx_ack_d;
      tx_wr_q      <= tx_wr_d;
      tx_data_q    <= tx_data_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_start_q  <= cpu_start_d;
      wc_q         <= wc_d;
      ovf_q        <= ovf_d;
      wptr_q       <= wptr_d;
      nib_q        <= nib_d;
      shift_q      <= shift_d;
      go_q         <= go_d;
`ifdef BOOT_CSUM_EN
      csum_q       <= csum_d;
      gap_q        <= gap_d;
`endif
    end
  end

  assign bus.rx_ack     = rx_ack_q;
  assign bus.tx_wr      = tx_wr_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_start      = cpu_start_q;
  assign word_count     = wc_q;
  assign overflow       = ovf_q;

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
Boot sequencer between the UART byte interface and the CPU instruction memory write port. Parses ASCII hex from the host, assembles 32-bit words MSB-nibble first, writes them to consecutive imem addresses and echoes every byte. It also owns the CPU start/stop control: 'G' runs the CPU, 'R' stops it and rewinds loading.

Parameters:
DEPTH, 16, number of 32-bit instruction words in imem
AW, 4, imem address width; DEPTH == 2**AW

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
rx_data  in  8  received UART byte
rx_valid  in  1  UART receive ready flag; stays high until acked
rx_ack  out  1  one-cycle pulse; clears the UART ready flag
tx_data  out  8  byte to transmit
tx_wr  out  1  one-cycle transmit strobe
tx_busy  in  1  UART transmitter busy
imem_we  out  1  one-cycle imem write strobe
imem_addr  out  AW  imem write address
imem_wdata  out  32  imem write data
cpu_start  out  1  level; high = CPU pipeline runs
word_count  out  AW+1  words written since reset or 'R' (0..DEPTH)
overflow  out  1  sticky; a complete word arrived with imem full

Behaviour:
- Reset: all outputs 0. Internal state: wptr=0, nibble count=0, shift reg=0, checksum=0, state IDLE.
- States: IDLE, GUARD, CSUM_WAIT_HI, CSUM_HI, CSUM_WAIT_LO, CSUM_LO (the CSUM_* states exist only with BOOT_CSUM_EN).
- Accept rule: in IDLE, if rx_valid=1 and tx_busy=0 at an edge, the byte is accepted. On the next cycle rx_ack=1, tx_wr=1 and tx_data=byte (echo), all for exactly one cycle, then state = GUARD.
- GUARD lasts one cycle and ignores rx_valid and tx_busy, which covers UART flag-clear and busy-rise latency. It then returns to IDLE, or goes to CSUM_WAIT_HI when the byte was 'G' and BOOT_CSUM_EN is set.
- rx_valid=1 while tx_busy=1: no accept and no ack; the loader waits.
- Hex chars '0'-'9', 'A'-'F', 'a'-'f' are processed only while cpu_start=0:
  - shift = {shift[27:0], nib}; nibble count +1.
  - On the 8th nibble, if word_count < DEPTH: in the same cycle as the echo, imem_we=1, imem_addr=wptr, imem_wdata=complete word. Then wptr+1 (wraps only via 'R'), word_count+1, checksum += the 4 bytes of the word (mod 256).
  - On the 8th nibble, if word_count == DEPTH: no write and overflow<=1. The nibble count resets in both cases.
- 'G'/'g' with cpu_start=0: discard any partial word (nibble count=0), then set cpu_start=1 (without BOOT_CSUM_EN, on the cycle after the echo). 'G' with cpu_start=1 has no effect beyond the echo.
- 'R'/'r': cpu_start=0, wptr=0, word_count=0, nibble count=0, overflow=0, checksum=0. This is legal in any state from IDLE.
- While cpu_start=1, hex chars are echoed only: no imem_we, and imem is locked.
- Every other byte (whitespace, CR/LF, punctuation) is echoed only, and the partial word is kept.
- rst_n low mid-word or mid-checksum: state aborts immediately and all registers take their reset values. No imem_we may be issued during or after the reset assertion until a new 8-nibble word completes.
- imem_addr and imem_wdata may hold stale values when imem_we=0.

Optional Feature:
BOOT_CSUM_EN
- Defined: after the 'G' echo and GUARD, the loader reports the checksum before starting the CPU.
  - CSUM_WAIT_HI waits for tx_busy=0, then CSUM_HI sends one tx_wr carrying the uppercase ASCII hex of checksum[7:4], followed by one guard cycle.
  - CSUM_WAIT_LO / CSUM_LO do the same for checksum[3:0].
  - cpu_start rises on the cycle after the low-digit guard cycle.
  - rx_valid is not acked during the report.
- Undefined: no checksum register, no CSUM states, and 'G' starts the CPU directly.

Test Plan:
- Reset, send "00500193" at 1-byte spacing -> 8 echoes identical to input, one imem_we with addr 0 and data 0x00500193, word_count=1.
- Send "dead beef" (space inside) -> space echoed, imem_we with addr 0 and data 0xDEADBEEF; then "00000013" -> addr 1, data 0x00000013.
- Load 17 words -> exactly 16 imem_we pulses (addr 0..15), overflow=1 after the 17th, word_count=16; 'R' -> overflow=0, word_count=0.
- Send "123G" then "ABCDEF01" -> cpu_start=1, partial discarded, no imem_we for "ABCDEF01"; 'r' -> cpu_start=0. Hold rx_valid while tx_busy=1 -> no rx_ack until tx_busy falls.
- BOOT_CSUM_EN: load 0x00500193, send 'G' -> tx bytes 'G', 'E', '4' in order (sum 0xE4), cpu_start high only after '4' is sent.
- Send "0050", pulse rst_n low for 3 cycles, then "00000013" -> all outputs 0 during reset, single write with addr 0 and data 0x00000013.
